// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: receive-only PS/2 keyboard front end.
// Synchronizes and de-glitches the raw PS/2 clock and data lines,
// deserializes 11-bit device-to-host frames (start, 8 data LSB first,
// odd parity, stop) and strips the E0 (extended) and F0 (break) prefix
// bytes, so that each key event produces one qualified scancode.
//
// Ports:
//   CLK        in   system clock, all logic on posedge
//   RST        in   asynchronous active-low reset
//   PS2_CLK    in   raw PS/2 clock line (never driven)
//   PS2_DAT    in   raw PS/2 data line (never driven)
//   code       out  [7:0] scancode with prefixes removed, held until next code_valid
//   extended   out  code was preceded by E0
//   break_code out  code was preceded by F0 (key release)
//   code_valid out  one-cycle strobe, code/extended/break_code updated
//   frame_err  out  one-cycle strobe on start, parity, stop or timeout error
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] code,
  output logic       extended,
  output logic       break_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic [7:0]    code_q, code_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  // Input conditioning: two-flop synchronizers, then a level filter on
  // the clock that only follows the synchronized line once it has
  // disagreed with the filtered level for FILTER_LEN consecutive cycles.
  always_comb begin
    clk_s1_d = PS2_CLK;
    clk_s2_d = clk_s1_q;
    dat_s1_d = PS2_DAT;
    dat_s2_d = dat_s1_q;
    filt_d   = filt_q;
    fcnt_d   = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else                               fcnt_d = fcnt_q + FW'(1);
    end
  end

  assign fall = filt_q & ~filt_d;

  // Frame FSM, prefix tracking and registered outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tmo_d      = tmo_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    code_d     = code_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    if (fall) begin
      // A fall in the same cycle the timeout would expire wins.
      tmo_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        S_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = dat_s2_q;
          state_d  = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if ((^shift_q ^ parity_q) && dat_s2_q) begin
            if (shift_q == 8'hE0) begin
              ext_pend_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_pend_d = 1'b1;
            end else begin
              code_d     = shift_q;
              ext_d      = ext_pend_q;
              brk_d      = brk_pend_q;
              valid_d    = 1'b1;
              ext_pend_d = 1'b0;
              brk_pend_d = 1'b0;
            end
          end else begin
            err_d      = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d    = S_IDLE;
        tmo_d      = '0;
        err_d      = 1'b1;
        shift_d    = '0;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // Idle PS/2 lines sit high, so the synchronizers and filter reset
      // to 1 to avoid a spurious fall when reset is released.
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      code_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      code_q     <= code_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign code       = code_q;
  assign extended   = ext_q;
  assign break_code = brk_q;
  assign code_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: directed key sequences plus
// randomized frames, compared against a byte-level event model.
module tb_ps2_scancode_rx;

  localparam int HALF = 20;    // PS/2 half bit period in system clocks
  localparam int TMO  = 2000;  // shortened timeout for a quick run

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] code;
  logic       extended, break_code, code_valid, frame_err;

  ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(clk), .RST(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .code(code), .extended(extended), .break_code(break_code),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       is_err;
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_q[$];
  int  n_total = 0;
  int  n_bad   = 0;

  // Reference model state: pending prefixes and the held scancode.
  bit          m_ext = 0, m_brk = 0;
  logic [7:0]  m_code = 8'h00;
  int unsigned last_fall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Event monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (rst_n && (code_valid || frame_err)) begin
      check("excl", 32'(code_valid & frame_err), 32'd0);
      if (code_valid) got_q.push_back(ev_t'{1'b0, extended, break_code, code});
      else            got_q.push_back(ev_t'{1'b1, 1'b0, 1'b0, 8'h00});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      wait_cyc(HALF);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  // Byte-level model of prefix stripping.
  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_q.push_back(ev_t'{1'b1, 1'b0, 1'b0, 8'h00});
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      exp_q.push_back(ev_t'{1'b0, m_ext, m_brk, b});
      m_code = b;
      m_ext  = 0;
      m_brk  = 0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(make_frame(b, bad_par, bad_stop), 11);
    wait_cyc(30);
    model_frame(b, !bad_par && !bad_stop);
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, ".n"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int unsigned t0, lat;
    logic [7:0]  b;
    int          k, e;

    // Reset state
    wait_cyc(3);
    check("rst.code", 32'(code), 32'h00);
    check("rst.ext", 32'(extended), 32'd0);
    check("rst.brk", 32'(break_code), 32'd0);
    check("rst.valid", 32'(code_valid), 32'd0);
    check("rst.err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    wait_cyc(20);

    // Make code
    send_frame(8'h1D, 0, 0);
    compare("make");
    check("make.code", 32'(code), 32'h1D);

    // Break: F0 alone must produce nothing
    send_frame(8'hF0, 0, 0);
    compare("brk.f0");
    send_frame(8'h1D, 0, 0);
    compare("brk");

    // Extended release, then plain make
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    compare("extrel");
    send_frame(8'h75, 0, 0);
    compare("plain");

    // Parity error keeps previous code
    send_frame(8'h1D, 1, 0);
    compare("parerr");
    check("parerr.hold", 32'(code), 32'(m_code));
    send_frame(8'h1B, 0, 0);
    compare("after_par");

    // Stop error
    send_frame(8'h3C, 0, 1);
    compare("stoperr");

    // Timeout after start plus 4 data bits
    send_bits(make_frame(8'h5A, 0, 0), 5);
    t0 = last_fall;
    while (got_q.size() == 0 && (cyc - t0) < TMO + 100) wait_cyc(1);
    lat = cyc - t0;
    check("tmo.early", 32'(lat >= TMO), 32'd1);
    check("tmo.late", 32'(lat <= TMO + 30), 32'd1);
    exp_q.push_back(ev_t'{1'b1, 1'b0, 1'b0, 8'h00});
    m_ext = 0;
    m_brk = 0;
    compare("tmo");
    send_frame(8'h29, 0, 0);
    compare("after_tmo");

    // Short glitch on idle clock line
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(50);
    compare("glitch");

    // Reset in the middle of a frame, after an E0 prefix
    send_frame(8'hE0, 0, 0);
    send_bits(make_frame(8'h6B, 0, 0), 5);
    compare("pre_rst");
    rst_n = 1'b0;
    wait_cyc(2);
    check("mrst.code", 32'(code), 32'h00);
    check("mrst.ext", 32'(extended), 32'd0);
    rst_n  = 1'b1;
    m_ext  = 0;
    m_brk  = 0;
    m_code = 8'h00;
    wait_cyc(100);
    compare("post_rst");
    send_frame(8'h72, 0, 0);
    compare("rst72");
    check("rst72.code", 32'(code), 32'h72);
    check("rst72.ext", 32'(extended), 32'd0);

    // Randomized frames with occasional errors
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = 8'hE1;
        default: b = 8'($urandom);
      endcase
      e = $urandom_range(0, 7);
      send_frame(b, e == 0, e == 1);
      compare("rnd");
    end
    check("rnd.hold", 32'(code), 32'(m_code));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
